// File: rtl/param_seq_alu_pkg.sv
// Shared types for the parametrised sequential lab ALU: op codes and FSM states.
package param_seq_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_ORR  = 3'd1,
      OP_ANDR = 3'd2,
      OP_CAT  = 3'd3,
      OP_MUL  = 3'd4,
      OP_ACC  = 3'd5,
      OP_ILL  = 3'd6,
      OP_CLR  = 3'd7
   } alu_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/param_seq_alu_if.sv
// Request/result bundle between the switch/key front end (master) and the ALU (slave).
interface param_seq_alu_if #(parameter int WIDTH = 4);

   logic                 start;
   logic [2:0]           func;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output start, func, a, b,
      input  busy, done, err, result
   );

   modport slave (
      input  start, func, a, b,
      output busy, done, err, result
   );

endinterface

// File: rtl/param_seq_alu_rca.sv
// N-bit ripple-carry adder built from a generated chain of full adders.
module rca_adder #(parameter int N = 4) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign sum[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[N];

endmodule

// File: rtl/param_seq_alu.sv
// Sequential ALU: single-cycle ops finish on the accepting edge, MUL runs a WIDTH-step shift-add.
module param_seq_alu
   import param_seq_alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic           clk,
   input  logic           resetn,
   param_seq_alu_if.slave bus
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   state_e          state;
   logic [RW-1:0]   result_q;
   logic [RW-1:0]   product;
   logic [RW-1:0]   mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]   cnt;
   logic            busy_q;
   logic            done_q;
   logic            err_q;

   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic [RW-1:0]    single_res;
   logic [RW-1:0]    mul_step;
   alu_op_e          op;

   assign op = alu_op_e'(bus.func);

   rca_adder #(.N(WIDTH)) u_add (
      .a    (bus.a),
      .b    (bus.b),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // One shift-add iteration; also the final product on the last MUL edge.
   assign mul_step = product + (mplier[0] ? mcand : '0);

   always_comb begin
      single_res = '0;
      case (op)
         OP_ADD:  single_res = {{(WIDTH-1){1'b0}}, add_cout, add_sum};
         OP_ORR:  single_res = RW'(|(bus.a | bus.b));
         OP_ANDR: single_res = RW'(&(bus.a & bus.b));
         OP_CAT:  single_res = {bus.a, bus.b};
         OP_ACC:  single_res = result_q + RW'(bus.a);
         default: single_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         result_q <= '0;
         product  <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  err_q <= (op == OP_ILL);
                  if (op == OP_MUL) begin
                     state   <= S_MUL;
                     busy_q  <= 1'b1;
                     product <= '0;
                     mcand   <= RW'(bus.a);
                     mplier  <= bus.b;
                     cnt     <= '0;
                  end else begin
                     result_q <= single_res;
                     done_q   <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               product <= mul_step;
               mcand   <= mcand << 1;
               mplier  <= mplier >> 1;
               cnt     <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  result_q <= mul_step;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.err    = err_q;

endmodule
